// File: rtl/pool_window_buffer.sv
// pool_window_buffer
//
// Turns a raster-order pixel stream into non-overlapping 2x2 windows
// (stride 2) for the max-pool stage that sits directly downstream.
// Even rows are stored in a one-row buffer. On odd rows the even-column
// pixel is held in a register. The odd-column pixel then completes a
// window, which is loaded into four output registers.
//
// Ports
//   clk, rst        rising-edge clock; asynchronous active-high reset
//   in_valid        upstream pixel valid
//   in_ready        block can accept a pixel this cycle
//   in_data         pixel value (DATA_W bits, passed through unmodified)
//   win_valid       window registers hold an unconsumed window
//   win_ready       downstream accepts the window
//   win_d1..win_d4  top-left, top-right, bottom-left, bottom-right pixel
//   frame_done      one-cycle pulse after the last pixel of a frame is accepted
//   win_count       (only with POOL_WIN_CNT_EN) windows handed off this frame
//
// Optional feature macro: POOL_WIN_CNT_EN adds the win_count output.
//
// Handshake: a beat transfers on a rising edge where valid && ready are both
// high. On the input side, in_ready = !win_valid || win_ready, with no
// bubble. A held window therefore stalls the stream, while a window being
// consumed lets the next pixel in on the same edge. The producer keeps
// win_d1..win_d4 stable while win_valid && !win_ready. When a window is
// consumed and a new one is loaded on the same edge, win_valid stays high
// and the outputs carry the new data.
module pool_window_buffer #(
  parameter int DATA_W = 16,
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              win_valid,
  input  logic              win_ready,
  output logic [DATA_W-1:0] win_d1,
  output logic [DATA_W-1:0] win_d2,
  output logic [DATA_W-1:0] win_d3,
  output logic [DATA_W-1:0] win_d4,
  output logic              frame_done
`ifdef POOL_WIN_CNT_EN
  ,
  output logic [$clog2((IMG_W/2)*(IMG_H/2)+1)-1:0] win_count
`endif
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  generate
    if ((IMG_W < 2) || (IMG_W % 2 != 0) || (IMG_H < 2) || (IMG_H % 2 != 0)) begin : g_bad_geometry
      $error("pool_window_buffer: IMG_W and IMG_H must be even and >= 2");
    end
  endgenerate

  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic [CW-1:0]     col_left;
  logic [DATA_W-1:0] held;
  logic [DATA_W-1:0] rowbuf [IMG_W];
  logic              accept;
  logic              col_last;
  logic              row_last;
  logic              win_load;
  logic              win_take;

  assign in_ready = !win_valid || win_ready;
  assign accept   = in_valid && in_ready;
  assign col_last = (col == COL_LAST);
  assign row_last = (row == ROW_LAST);
  // Only meaningful on odd columns, where col-1 is the window's left column.
  assign col_left = col - CW'(1);
  assign win_load = accept && row[0] && col[0];
  assign win_take = win_valid && win_ready;

  // Row buffer contents need no reset: every entry is rewritten on the even
  // row before the following odd row reads it.
  always_ff @(posedge clk) begin
    if (accept && !row[0]) begin
      rowbuf[col] <= in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col        <= '0;
      row        <= '0;
      held       <= '0;
      win_valid  <= 1'b0;
      win_d1     <= '0;
      win_d2     <= '0;
      win_d3     <= '0;
      win_d4     <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= accept && row_last && col_last;
      if (accept) begin
        if (col_last) begin
          col <= '0;
          row <= row_last ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
        if (row[0] && !col[0]) begin
          held <= in_data;
        end
      end
      // A new window has priority over consumption; a same-edge consume is
      // covered because win_valid simply stays set.
      if (win_load) begin
        win_d1    <= rowbuf[col_left];
        win_d2    <= rowbuf[col];
        win_d3    <= held;
        win_d4    <= in_data;
        win_valid <= 1'b1;
      end else if (win_take) begin
        win_valid <= 1'b0;
      end
    end
  end

`ifdef POOL_WIN_CNT_EN
  localparam int CNT_W = $clog2((IMG_W/2)*(IMG_H/2)+1);

  // frame_done delayed one cycle: the count restarts on the edge that ends
  // the cycle after frame_done, so the final window's count is still visible.
  logic fd_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fd_q      <= 1'b0;
      win_count <= '0;
    end else begin
      fd_q <= frame_done;
      if (win_take) begin
        win_count <= fd_q ? CNT_W'(1) : win_count + CNT_W'(1);
      end else if (fd_q) begin
        win_count <= '0;
      end
    end
  end
`endif

endmodule
